// File: rtl/pc_pkg.sv
// Shared next-PC definitions: sequencer state encoding, default vectors and PC step.
package pc_pkg;

  // Sequencer states
  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0040_0000;
  localparam logic [31:0] EXC_VECTOR_DEF   = 32'h0040_0004;
  localparam logic [31:0] PC_STEP          = 32'd4;

  // Word-align a redirect target by clearing the byte-offset bits
  function automatic logic [31:0] align_pc(input logic [31:0] target);
    return {target[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_pend_buf.sv
// Pending-request buffer: remembers a redirect or exception that arrived while
// the PC could not advance. An exception discards any pending redirect and blocks
// later redirects; a newer redirect overwrites an older one.
module pc_pend_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        set_exc,
  input  logic        set_redir,
  input  logic [31:0] redir_target,
  output logic        pend_valid,
  output logic        pend_exc,
  output logic [31:0] pend_target
);

  // Pending entry update: clear on apply, exception beats redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid  <= 1'b0;
      pend_exc    <= 1'b0;
      pend_target <= 32'd0;
    end else if (clr) begin
      pend_valid <= 1'b0;
      pend_exc   <= 1'b0;
    end else if (set_exc) begin
      pend_exc   <= 1'b1;
      pend_valid <= 1'b0;
    end else if (set_redir && !pend_exc) begin
      pend_valid  <= 1'b1;
      pend_target <= redir_target;
    end
  end

endmodule

// File: rtl/pc_next_ctrl.sv
// Next-PC sequencer feeding pcreg. Outputs are combinational from state and inputs
// so pcreg loads the selected PC on the same clock edge.
//
// Handshake: pc_ena/pc_next act as valid/data toward pcreg; advance
// (imem_ready & ~stall) acts as ready. A PC is loaded only in a cycle where both
// are high (BOOT forces the reset vector unconditionally); requests seen while
// ready is low are held in the pending buffer until the next ready cycle.
module pc_next_ctrl
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pc_cur,
  input  logic             imem_ready,
  input  logic             stall,
  input  logic             redir_valid,
  input  logic [31:0]      redir_target,
  input  logic             exc_valid,
  output logic [31:0]      pc_next,
  output logic             pc_ena,
  output logic             flush,
  output logic             misalign,
  output logic [CNT_W-1:0] stall_cycles
);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        advance;
  logic        active;
  logic        pend_valid;
  logic        pend_exc;
  logic [31:0] pend_target;
  logic        pend_clr;
  logic        pend_set_exc;
  logic        pend_set_redir;

  assign advance        = imem_ready & ~stall;
  assign active         = (state != ST_BOOT);
  assign pend_clr       = active & advance;
  assign pend_set_exc   = active & ~advance & exc_valid;
  assign pend_set_redir = active & ~advance & redir_valid;

  pc_pend_buf u_pend (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (pend_clr),
    .set_exc      (pend_set_exc),
    .set_redir    (pend_set_redir),
    .redir_target (redir_target),
    .pend_valid   (pend_valid),
    .pend_exc     (pend_exc),
    .pend_target  (pend_target)
  );

  // Source selection, output drive and next-state decision
  always_comb begin
    pc_next   = pc_cur;
    pc_ena    = 1'b0;
    flush     = 1'b0;
    misalign  = 1'b0;
    state_nxt = state;
    if (!active) begin
      // pc_ena follows rst_n so it stays low while reset is asserted
      pc_next   = RESET_VECTOR;
      pc_ena    = rst_n;
      state_nxt = ST_RUN;
    end else if (advance) begin
      pc_ena    = 1'b1;
      state_nxt = ST_RUN;
      if (exc_valid || pend_exc) begin
        pc_next = EXC_VECTOR;
        flush   = 1'b1;
      end else if (redir_valid) begin
        pc_next  = align_pc(redir_target);
        flush    = 1'b1;
        misalign = |redir_target[1:0];
      end else if (pend_valid) begin
        pc_next  = align_pc(pend_target);
        flush    = 1'b1;
        misalign = |pend_target[1:0];
      end else begin
        pc_next = pc_cur + PC_STEP;
      end
    end else begin
      if (exc_valid || redir_valid || pend_exc || pend_valid) state_nxt = ST_HOLD;
      else                                                   state_nxt = ST_RUN;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_BOOT;
    else        state <= state_nxt;
  end

  // Saturating count of cycles the PC was blocked outside BOOT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (active && !advance && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pc_next_ctrl.sv
// Directed bench for pc_next_ctrl: inputs change just after the falling edge,
// combinational outputs are checked #1 later, state advances on the rising edge.
module tb_pc_next_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_cur;
  logic        imem_ready;
  logic        stall;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic        exc_valid;
  logic [31:0] pc_next;
  logic        pc_ena;
  logic        flush;
  logic        misalign;
  logic [15:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  pc_next_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_cur       (pc_cur),
    .imem_ready   (imem_ready),
    .stall        (stall),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .exc_valid    (exc_valid),
    .pc_next      (pc_next),
    .pc_ena       (pc_ena),
    .flush        (flush),
    .misalign     (misalign),
    .stall_cycles (stall_cycles)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge
  task automatic drive(input logic [31:0] pc, input logic rdy, input logic stl,
                       input logic rv, input logic [31:0] rt, input logic ev);
    @(negedge clk);
    pc_cur       = pc;
    imem_ready   = rdy;
    stall        = stl;
    redir_valid  = rv;
    redir_target = rt;
    exc_valid    = ev;
    #1;
  endtask

  task automatic chk_out(input string tag, input logic ena, input logic [31:0] nxt,
                         input logic fl, input logic mis);
    chk({tag, "_ena"},  {31'd0, pc_ena},   {31'd0, ena});
    chk({tag, "_next"}, pc_next,           nxt);
    chk({tag, "_flush"},{31'd0, flush},    {31'd0, fl});
    chk({tag, "_mis"},  {31'd0, misalign}, {31'd0, mis});
  endtask

  initial begin
    rst_n = 1'b0; pc_cur = 32'd0; imem_ready = 1'b0; stall = 1'b0;
    redir_valid = 1'b0; redir_target = 32'd0; exc_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk_out("reset", 1'b0, 32'h0040_0000, 1'b0, 1'b0);
    chk("reset_cnt", {16'd0, stall_cycles}, 32'd0);

    // BOOT: reset vector regardless of request, which is dropped
    @(negedge clk);
    rst_n = 1'b1; imem_ready = 1'b1; redir_valid = 1'b1; redir_target = 32'h0000_1234;
    #1;
    chk_out("boot", 1'b1, 32'h0040_0000, 1'b0, 1'b0);

    // Sequential +4
    drive(32'h0040_0000, 1, 0, 0, 32'd0, 0);
    chk_out("seq0", 1'b1, 32'h0040_0004, 1'b0, 1'b0);
    drive(32'h0040_0004, 1, 0, 0, 32'd0, 0);
    chk_out("seq1", 1'b1, 32'h0040_0008, 1'b0, 1'b0);

    // Immediate redirect
    drive(32'h0040_0010, 1, 0, 1, 32'h0040_0100, 0);
    chk_out("redir", 1'b1, 32'h0040_0100, 1'b1, 1'b0);
    drive(32'h0040_0100, 1, 0, 0, 32'd0, 0);
    chk_out("after_redir", 1'b1, 32'h0040_0104, 1'b0, 1'b0);

    // Stall 3 cycles with misaligned redirect in the first
    drive(32'h0040_0104, 1, 1, 1, 32'h0040_0203, 0);
    chk_out("stall1", 1'b0, 32'h0040_0104, 1'b0, 1'b0);
    chk("stall1_cnt", {16'd0, stall_cycles}, 32'd0);
    drive(32'h0040_0104, 1, 1, 0, 32'd0, 0);
    chk_out("stall2", 1'b0, 32'h0040_0104, 1'b0, 1'b0);
    drive(32'h0040_0104, 1, 1, 0, 32'd0, 0);
    chk_out("stall3", 1'b0, 32'h0040_0104, 1'b0, 1'b0);
    chk("stall3_cnt", {16'd0, stall_cycles}, 32'd2);
    drive(32'h0040_0104, 1, 0, 0, 32'd0, 0);
    chk("stall_done_cnt", {16'd0, stall_cycles}, 32'd3);
    chk_out("pend_apply", 1'b1, 32'h0040_0200, 1'b1, 1'b1);
    drive(32'h0040_0200, 1, 0, 0, 32'd0, 0);
    chk_out("post_pend", 1'b1, 32'h0040_0204, 1'b0, 1'b0);

    // Pending redirect superseded by exception while blocked
    drive(32'h0040_0204, 0, 0, 1, 32'h0040_0300, 0);
    chk_out("hold_redir", 1'b0, 32'h0040_0204, 1'b0, 1'b0);
    drive(32'h0040_0204, 0, 0, 0, 32'd0, 1);
    chk_out("hold_exc", 1'b0, 32'h0040_0204, 1'b0, 1'b0);
    drive(32'h0040_0204, 0, 0, 0, 32'd0, 0);
    chk_out("hold_idle", 1'b0, 32'h0040_0204, 1'b0, 1'b0);
    drive(32'h0040_0204, 1, 0, 0, 32'd0, 0);
    chk_out("exc_apply", 1'b1, 32'h0040_0004, 1'b1, 1'b0);
    chk("exc_cnt", {16'd0, stall_cycles}, 32'd6);
    drive(32'h0040_0004, 1, 0, 0, 32'd0, 0);
    chk_out("no_redir", 1'b1, 32'h0040_0008, 1'b0, 1'b0);

    // Simultaneous exception and redirect while advancing
    drive(32'h0040_0008, 1, 0, 1, 32'h0040_0800, 1);
    chk_out("exc_vs_redir", 1'b1, 32'h0040_0004, 1'b1, 1'b0);
    drive(32'h0040_0004, 1, 0, 0, 32'd0, 0);
    chk_out("redir_dropped", 1'b1, 32'h0040_0008, 1'b0, 1'b0);

    // Newest pending redirect overwrites older
    drive(32'h0040_0008, 1, 1, 1, 32'h0040_0500, 0);
    drive(32'h0040_0008, 1, 1, 1, 32'h0040_0600, 0);
    drive(32'h0040_0008, 1, 0, 0, 32'd0, 0);
    chk_out("overwrite", 1'b1, 32'h0040_0600, 1'b1, 1'b0);
    chk("overwrite_cnt", {16'd0, stall_cycles}, 32'd8);

    // Wrap of pc_cur+4
    drive(32'hFFFF_FFFC, 1, 0, 0, 32'd0, 0);
    chk_out("wrap", 1'b1, 32'h0000_0000, 1'b0, 1'b0);

    // Reset asserted mid-HOLD
    drive(32'h0000_0000, 1, 1, 1, 32'h0040_0700, 0);
    chk_out("hold_pre_rst", 1'b0, 32'h0000_0000, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 32'h0040_0000, 1'b0, 1'b0);
    chk("async_rst_cnt", {16'd0, stall_cycles}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; stall = 1'b0; redir_valid = 1'b0; pc_cur = 32'd0;
    #1;
    chk_out("reboot", 1'b1, 32'h0040_0000, 1'b0, 1'b0);
    drive(32'h0040_0000, 1, 0, 0, 32'd0, 0);
    chk_out("pend_lost", 1'b1, 32'h0040_0004, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety bound on total run time
  initial begin
    #100000;
    errors++;
    $display("FAIL timeout observed running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
